// File: rtl/fpga_fifo_pkg.sv
// Shared constants and types for the SDPRAM-backed FWFT FIFO controller.
// Sizing of the output buffer and the level counter are derived here.
package fpga_fifo_pkg;

  // One slot per read-pipeline stage plus one, so reads stream without bubbles.
  function automatic int unsigned obuf_depth(input int unsigned read_laten);
    return read_laten + 1;
  endfunction

  // Level counts RAM words plus in-flight reads plus output buffer words.
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

  typedef struct packed {
    logic push;
    logic rd_issue;
    logic ret;
    logic pop;
  } fifo_op_t;

endpackage

// File: rtl/fpga_sdpram_sync.sv
// Simple dual-port RAM, common clock, port A write / port B read,
// READ_LATEN 1 (output latch) or 2 (extra output register).
module fpga_sdpram_sync #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned READ_LATEN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wea,
  input  logic                  ena,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_d, rd_q;

  // NOTE: the storage array has no reset so it maps onto block RAM; only the
  // output registers are reset.
  always_ff @(posedge clk) begin
    if (ena && wea) mem[addra] <= dina;
  end

  always_comb begin
    rd_d = rd_q;
    if (enb) rd_d = mem[addrb];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else        rd_q <= rd_d;
  end

  if (READ_LATEN >= 2) begin : g_oreg
    logic [DATA_WIDTH-1:0] oreg_d, oreg_q;
    always_comb oreg_d = rd_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) oreg_q <= '0;
      else        oreg_q <= oreg_d;
    end
    assign doutb = oreg_q;
  end else begin : g_noreg
    assign doutb = rd_q;
  end

endmodule

// File: rtl/fpga_sdpram_fifo_ctrl.sv
// First-word-fall-through FIFO on a synchronous SDPRAM: a small credit-managed
// output buffer hides the RAM read latency and sustains one word per clock.
module fpga_sdpram_fifo_ctrl
  import fpga_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned READ_LATEN = 1,
  localparam int unsigned LVL_W     = level_width(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [LVL_W-1:0]      level,
  output logic                  empty,
  output logic                  ovf,
  output logic                  udf
);

  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;
  localparam int unsigned RAM_CW     = ADDR_WIDTH + 1;
  localparam int unsigned OBUF_DEPTH = obuf_depth(READ_LATEN);
  localparam int unsigned OB_PW      = $clog2(OBUF_DEPTH);
  localparam int unsigned OB_CW      = $clog2(OBUF_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
  logic [RAM_CW-1:0]     ram_cnt_d, ram_cnt_q;
  logic [READ_LATEN-1:0] tag_d, tag_q;
  logic [DATA_WIDTH-1:0] obuf_d [OBUF_DEPTH];
  logic [DATA_WIDTH-1:0] obuf_q [OBUF_DEPTH];
  logic [OB_PW-1:0]      ob_head_d, ob_head_q, ob_tail_d, ob_tail_q;
  logic [OB_CW-1:0]      ob_cnt_d, ob_cnt_q;
  logic                  ovf_d, ovf_q, udf_d, udf_q;

  logic [OB_CW-1:0]      inflight;
  logic [2:0]            credit;
  logic [DATA_WIDTH-1:0] ram_doutb;
  fifo_op_t              op;

  function automatic logic [OB_PW-1:0] ob_inc(input logic [OB_PW-1:0] p);
    return (p == OB_PW'(OBUF_DEPTH - 1)) ? '0 : p + OB_PW'(1);
  endfunction

  // Status is derived from registered state only; no request input reaches it.
  assign inflight = OB_CW'($countones(tag_q));
  assign full     = (ram_cnt_q == RAM_CW'(DEPTH));
  assign dout_vld = (ob_cnt_q != '0);
  assign dout     = obuf_q[ob_head_q];
  assign level    = LVL_W'(ram_cnt_q) + LVL_W'(inflight) + LVL_W'(ob_cnt_q);
  assign empty    = (level == '0);
  assign ovf      = ovf_q;
  assign udf      = udf_q;

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    op        = '0;
    credit    = '0;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ram_cnt_d = ram_cnt_q;
    tag_d     = tag_q;
    obuf_d    = obuf_q;
    ob_head_d = ob_head_q;
    ob_tail_d = ob_tail_q;
    ob_cnt_d  = ob_cnt_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;

    if (clr) begin
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      tag_d     = '0;
      obuf_d    = '{default: '0};
      ob_head_d = '0;
      ob_tail_d = '0;
      ob_cnt_d  = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end else begin
      op.push = wr_en & ~full;
      op.pop  = dout_vld & dout_rdy;
      op.ret  = tag_q[READ_LATEN-1];
      // A pop this cycle frees a slot; a returning word only moves between
      // the in-flight and buffered counts, so it is neutral for credit.
      credit      = 3'(ob_cnt_q) + 3'(inflight) - 3'(op.pop);
      op.rd_issue = (ram_cnt_q != '0) && (credit < 3'(OBUF_DEPTH));

      wptr_d    = wptr_q + ADDR_WIDTH'(op.push);
      rptr_d    = rptr_q + ADDR_WIDTH'(op.rd_issue);
      ram_cnt_d = ram_cnt_q + RAM_CW'(op.push) - RAM_CW'(op.rd_issue);
      tag_d     = READ_LATEN'({tag_q, op.rd_issue});

      if (op.ret) begin
        obuf_d[ob_tail_q] = ram_doutb;
        ob_tail_d         = ob_inc(ob_tail_q);
      end
      if (op.pop) ob_head_d = ob_inc(ob_head_q);
      ob_cnt_d = ob_cnt_q + OB_CW'(op.ret) - OB_CW'(op.pop);

      ovf_d = ovf_q | (wr_en & full);
      udf_d = udf_q | (dout_rdy & ~dout_vld);
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      tag_q     <= '0;
      obuf_q    <= '{default: '0};
      ob_head_q <= '0;
      ob_tail_q <= '0;
      ob_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      tag_q     <= tag_d;
      obuf_q    <= obuf_d;
      ob_head_q <= ob_head_d;
      ob_tail_q <= ob_tail_d;
      ob_cnt_q  <= ob_cnt_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Reads only issue with ram_cnt != 0 and writes only below DEPTH, so the two
  // port addresses can never coincide while both ports are active.
  fpga_sdpram_sync #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .READ_LATEN (READ_LATEN)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .wea   (1'b1),
    .ena   (op.push),
    .addra (wptr_q),
    .dina  (wr_data),
    .enb   (op.rd_issue),
    .addrb (rptr_q),
    .doutb (ram_doutb)
  );

endmodule

// File: tb/tb_fpga_sdpram_fifo_ctrl.sv
// Directed bench: two FIFOs (READ_LATEN 1 and 2, 16-word RAM) driven by the
// same stimulus, each compared against hand-derived expectations.
module tb_fpga_sdpram_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LW = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n, clr, wr_en, dout_rdy;
  logic [DW-1:0] wr_data;

  logic          full_a, dout_vld_a, empty_a, ovf_a, udf_a;
  logic [DW-1:0] dout_a;
  logic [LW-1:0] level_a;
  logic          full_b, dout_vld_b, empty_b, ovf_b, udf_b;
  logic [DW-1:0] dout_b;
  logic [LW-1:0] level_b;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_a, exp_b, bub_a, bub_b, lv_a, lv_b, pushed, cyc, late;

  always #5 clk = ~clk;

  fpga_sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATEN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_a), .dout_vld(dout_vld_a), .dout_rdy(dout_rdy), .dout(dout_a),
    .level(level_a), .empty(empty_a), .ovf(ovf_a), .udf(udf_a)
  );

  fpga_sdpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_b), .dout_vld(dout_vld_b), .dout_rdy(dout_rdy), .dout(dout_b),
    .level(level_b), .empty(empty_b), .ovf(ovf_b), .udf(udf_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; wr_en = 1'b0; dout_rdy = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_full_a"},  full_a,     0);
    check({tag, "_empty_a"}, empty_a,    1);
    check({tag, "_vld_a"},   dout_vld_a, 0);
    check({tag, "_level_a"}, level_a,    0);
    check({tag, "_ovf_a"},   ovf_a,      0);
    check({tag, "_udf_a"},   udf_a,      0);
    check({tag, "_dout_a"},  dout_a,     0);
    check({tag, "_empty_b"}, empty_b,    1);
    check({tag, "_vld_b"},   dout_vld_b, 0);
    check({tag, "_level_b"}, level_b,    0);
    check({tag, "_udf_b"},   udf_b,      0);
    check({tag, "_dout_b"},  dout_b,     0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; dout_rdy = 1'b0; wr_data = '0;
    #2;
    check_reset_state("rst");
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // First-word latency: push at edge N, visible after N+1+READ_LATEN.
    wr_en = 1'b1; wr_data = 8'hA5; dout_rdy = 1'b1;
    step();
    wr_en = 1'b0;
    check("lat_n0_vld_a", dout_vld_a, 0);
    check("lat_n0_vld_b", dout_vld_b, 0);
    step();
    check("lat_n1_vld_a", dout_vld_a, 0);
    check("lat_n1_vld_b", dout_vld_b, 0);
    step();
    check("lat_n2_vld_a", dout_vld_a, 1);
    check("lat_n2_dout_a", dout_a, 8'hA5);
    check("lat_n2_vld_b", dout_vld_b, 0);
    step();
    check("lat_n3_vld_a", dout_vld_a, 0);
    check("lat_n3_vld_b", dout_vld_b, 1);
    check("lat_n3_dout_b", dout_b, 8'hA5);
    step();
    check("lat_n4_empty_b", empty_b, 1);
    check("lat_udf_a", udf_a, 1);
    check("lat_udf_b", udf_b, 1);
    do_clr();
    check("clr_udf_a", udf_a, 0);
    check("clr_udf_b", udf_b, 0);
    check("clr_empty_a", empty_a, 1);

    // Fill with no consumer: A holds 16+2, B holds 16+3.
    for (int i = 1; i <= 20; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 17) begin
        check("fill17_full_a", full_a, 0);
        check("fill17_level_a", level_a, 17);
      end
      if (i == 18) begin
        check("fill18_full_a", full_a, 1);
        check("fill18_level_a", level_a, 18);
        check("fill18_ovf_a", ovf_a, 0);
        check("fill18_full_b", full_b, 0);
        check("fill18_level_b", level_b, 18);
      end
      if (i == 19) begin
        check("fill19_ovf_a", ovf_a, 1);
        check("fill19_level_a", level_a, 18);
        check("fill19_full_b", full_b, 1);
        check("fill19_level_b", level_b, 19);
        check("fill19_ovf_b", ovf_b, 0);
      end
      if (i == 20) begin
        check("fill20_ovf_b", ovf_b, 1);
        check("fill20_level_b", level_b, 19);
      end
    end
    wr_en = 1'b0;

    // Drain: dropped pushes must not appear.
    dout_rdy = 1'b1; exp_a = 1; exp_b = 1;
    for (int c = 0; c < 30; c++) begin
      if (dout_vld_a) begin check("drain_a", dout_a, exp_a); exp_a++; end
      if (dout_vld_b) begin check("drain_b", dout_b, exp_b); exp_b++; end
      step();
    end
    check("drain_a_cnt", exp_a, 19);
    check("drain_b_cnt", exp_b, 20);
    do_clr();

    // Streaming 0..255 with the consumer always ready.
    exp_a = 0; exp_b = 0; bub_a = 0; bub_b = 0; lv_a = 0; lv_b = 0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 264; i++) begin
      wr_en = (i < 256); wr_data = 8'(i);
      step();
      if (dout_vld_a) begin check("stream_a", dout_a, exp_a); exp_a++; end
      else if (exp_a > 0 && exp_a < 256) bub_a++;
      if (dout_vld_b) begin check("stream_b", dout_b, exp_b); exp_b++; end
      else if (exp_b > 0 && exp_b < 256) bub_b++;
      if (i >= 2 && i <= 255 && level_a != 6'd3) lv_a++;
      if (i >= 3 && i <= 255 && level_b != 6'd4) lv_b++;
    end
    wr_en = 1'b0;
    check("stream_a_cnt", exp_a, 256);
    check("stream_b_cnt", exp_b, 256);
    check("stream_a_bubbles", bub_a, 0);
    check("stream_b_bubbles", bub_b, 0);
    check("stream_a_level_dev", lv_a, 0);
    check("stream_b_level_dev", lv_b, 0);
    check("stream_ovf_a", ovf_a, 0);
    do_clr();

    // Random back-pressure, 1000 words.
    pushed = 0; exp_a = 0; exp_b = 0; cyc = 0;
    while ((exp_a < 1000 || exp_b < 1000) && cyc < 20000) begin
      wr_en    = (pushed < 1000) && !full_a && !full_b;
      wr_data  = pushed[7:0];
      dout_rdy = ($urandom_range(1) == 1) && dout_vld_a && dout_vld_b;
      if (dout_rdy) begin
        check("rand_a", dout_a, exp_a & 32'hFF); exp_a++;
        check("rand_b", dout_b, exp_b & 32'hFF); exp_b++;
      end
      if (wr_en) pushed++;
      step();
      cyc++;
    end
    wr_en = 1'b0; dout_rdy = 1'b0;
    check("rand_a_cnt", exp_a, 1000);
    check("rand_b_cnt", exp_b, 1000);
    check("rand_ovf_a", ovf_a, 0);
    check("rand_udf_a", udf_a, 0);
    check("rand_ovf_b", ovf_b, 0);
    check("rand_udf_b", udf_b, 0);
    step();
    check("rand_empty_b", empty_b, 1);

    // Flush with reads in flight at level 10.
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h21 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (4) step();
    check("pre_clr_level_a", level_a, 10);
    check("pre_clr_level_b", level_b, 10);
    wr_en = 1'b1; wr_data = 8'h2B; dout_rdy = 1'b1;
    step();
    check("pushpop_level_a", level_a, 10);
    check("pushpop_level_b", level_b, 10);
    clr = 1'b1;
    step();
    clr = 1'b0; wr_en = 1'b0; dout_rdy = 1'b0;
    check("flush_level_a", level_a, 0);
    check("flush_level_b", level_b, 0);
    check("flush_empty_a", empty_a, 1);
    check("flush_empty_b", empty_b, 1);
    check("flush_vld_a", dout_vld_a, 0);
    check("flush_vld_b", dout_vld_b, 0);
    late = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (dout_vld_a || dout_vld_b || level_a != 0 || level_b != 0) late++;
    end
    check("flush_late_data", late, 0);

    // Asynchronous reset in the middle of a stream.
    dout_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h31 + i);
      step();
    end
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    wr_en = 1'b0; dout_rdy = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst_vld_a", dout_vld_a, 0);
    dout_rdy = 1'b1;
    step();
    check("post_rst_udf_a", udf_a, 1);
    check("post_rst_udf_b", udf_b, 1);
    dout_rdy = 1'b0; wr_en = 1'b1; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    step();
    check("post_rst_n1_vld_a", dout_vld_a, 0);
    step();
    check("post_rst_n2_vld_a", dout_vld_a, 1);
    check("post_rst_n2_dout_a", dout_a, 8'h5A);
    check("post_rst_n2_vld_b", dout_vld_b, 0);
    step();
    check("post_rst_n3_vld_b", dout_vld_b, 1);
    check("post_rst_n3_dout_b", dout_b, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
